data_mem_mmio: RTL and testbench

Parametrised data memory with byte-lane writes, a sequential clear engine, and a small MMIO peripheral block (timer, LEDs, 7-segment digits). It sits in the MEM stage of the pipelined CPU: combinational read, synchronous write. It extends the fixed 512-word RAM plus digit register with configurable depth, byte enables, a timer with interrupt, and a busy-flagged clear-on-reset.

---
 rtl/data_mem_mmio.sv | 142 ++++++++++++++
 tb/tb_data_mem_mmio.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// MEM-stage data RAM with byte-lane writes, reset-time clear engine and MMIO timer/LED/digit block.
// Reads are combinational, writes are synchronous. CPU accesses are blocked while the clear engine runs.
module data_mem_mmio #(
    parameter int          ADDR_WIDTH = 9,
    parameter logic [31:0] MMIO_BASE  = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [3:0]  ByteEn,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Busy,
    output logic [7:0]  Leds,
    output logic [11:0] RAM_Digi,
    output logic        TimerIrq
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [29:0] MMIO_W = MMIO_BASE[31:2];

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           th_q, th_d, tl_q, tl_d;
    logic [2:0]            tcon_q, tcon_d;
    logic [7:0]            leds_q, leds_d;
    logic [11:0]           digi_q, digi_d;

    logic                  busy, ram_hit, wr_ok;
    logic                  hit_th, hit_tl, hit_tcon, hit_leds, hit_digi;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           rd_word;
    logic                  unused_addr;

    assign busy        = (state_q == S_CLEAR);
    assign ram_hit     = (Addr[31:ADDR_WIDTH+2] == '0);
    assign widx        = Addr[ADDR_WIDTH+1:2];
    assign hit_th      = (Addr[31:2] == MMIO_W);
    assign hit_tl      = (Addr[31:2] == MMIO_W + 30'd1);
    assign hit_tcon    = (Addr[31:2] == MMIO_W + 30'd2);
    assign hit_leds    = (Addr[31:2] == MMIO_W + 30'd3);
    assign hit_digi    = (Addr[31:2] == MMIO_W + 30'd4);
    assign wr_ok       = MemWr & ~busy;
    assign unused_addr = ^Addr[1:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_ok && ram_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (ByteEn[k]) begin
                    mem_q[widx][8*k +: 8] <= WrData[8*k +: 8];
                end
            end
        end
    end

    // CPU writes are applied after the timer update so they win any same-cycle collision.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        leds_d = leds_q;
        digi_d = digi_q;
        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wr_ok) begin
            if (hit_th)   th_d   = WrData;
            if (hit_tl)   tl_d   = WrData;
            if (hit_tcon) tcon_d = WrData[2:0];
            if (hit_leds) leds_d = WrData[7:0];
            if (hit_digi) digi_d = WrData[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            leds_q <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            leds_q <= leds_d;
            digi_q <= digi_d;
        end
    end

    always_comb begin
        rd_word = '0;
        if (ram_hit)       rd_word = mem_q[widx];
        else if (hit_th)   rd_word = th_q;
        else if (hit_tl)   rd_word = tl_q;
        else if (hit_tcon) rd_word = {29'd0, tcon_q};
        else if (hit_leds) rd_word = {24'd0, leds_q};
        else if (hit_digi) rd_word = {20'd0, digi_q};
    end

    assign RdData   = (MemRd && !busy) ? rd_word : '0;
    assign Busy     = busy;
    assign Leds     = leds_q;
    assign RAM_Digi = digi_q;
    assign TimerIrq = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: reset/clear timing, table of RAM/MMIO accesses, timer corner cases.
module tb_data_mem_mmio;
    localparam logic [31:0] MB = 32'h4000_0000;
    localparam int OP_WR = 0, OP_RD = 1, OP_RDOFF = 2;

    logic        clk = 1'b0;
    logic        rst, MemRd, MemWr;
    logic [3:0]  ByteEn;
    logic [31:0] Addr, WrData, RdData;
    logic        Busy, TimerIrq;
    logic [7:0]  Leds;
    logic [11:0] RAM_Digi;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [21];

    data_mem_mmio dut (
        .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .ByteEn(ByteEn),
        .Addr(Addr), .WrData(WrData), .RdData(RdData), .Busy(Busy),
        .Leds(Leds), .RAM_Digi(RAM_Digi), .TimerIrq(TimerIrq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        MemWr = 1'b1; Addr = a; WrData = d; ByteEn = be;
        @(negedge clk);
        MemWr = 1'b0;
    endtask

    task automatic do_rd(input logic [31:0] a, output logic [31:0] d);
        MemRd = 1'b1; Addr = a;
        #1;
        d = RdData;
        MemRd = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          cnt;
        logic        bad;

        tbl[0]  = '{OP_WR,    32'h0000_0008, 32'h1122_3344, 4'hF, 32'h0};
        tbl[1]  = '{OP_RD,    32'h0000_0008, 32'h0,         4'h0, 32'h1122_3344};
        tbl[2]  = '{OP_WR,    32'h0000_0008, 32'hAABB_CCDD, 4'h5, 32'h0};
        tbl[3]  = '{OP_RD,    32'h0000_0008, 32'h0,         4'h0, 32'h11BB_33DD};
        tbl[4]  = '{OP_WR,    32'h0000_0800, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[5]  = '{OP_RD,    32'h0000_0800, 32'h0,         4'h0, 32'h0};
        tbl[6]  = '{OP_RD,    32'h0000_0000, 32'h0,         4'h0, 32'h0};
        tbl[7]  = '{OP_WR,    32'h0000_07FC, 32'h1234_5678, 4'h3, 32'h0};
        tbl[8]  = '{OP_RD,    32'h0000_07FC, 32'h0,         4'h0, 32'h0000_5678};
        tbl[9]  = '{OP_RDOFF, 32'h0000_0008, 32'h0,         4'h0, 32'h0};
        tbl[10] = '{OP_WR,    MB + 32'h0C,   32'h0000_0123, 4'h0, 32'h0};
        tbl[11] = '{OP_RD,    MB + 32'h0C,   32'h0,         4'h0, 32'h0000_0023};
        tbl[12] = '{OP_WR,    MB + 32'h10,   32'h0000_ABCD, 4'h0, 32'h0};
        tbl[13] = '{OP_RD,    MB + 32'h10,   32'h0,         4'h0, 32'h0000_0BCD};
        tbl[14] = '{OP_WR,    MB + 32'h14,   32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[15] = '{OP_RD,    MB + 32'h14,   32'h0,         4'h0, 32'h0};
        tbl[16] = '{OP_WR,    MB + 32'h08,   32'hFFFF_FFF8, 4'hF, 32'h0};
        tbl[17] = '{OP_RD,    MB + 32'h08,   32'h0,         4'h0, 32'h0};
        tbl[18] = '{OP_WR,    MB + 32'h00,   32'hCAFE_F00D, 4'h0, 32'h0};
        tbl[19] = '{OP_RD,    MB + 32'h00,   32'h0,         4'h0, 32'hCAFE_F00D};
        tbl[20] = '{OP_RD,    MB + 32'h04,   32'h0,         4'h0, 32'h0};

        rst = 1'b1; MemRd = 1'b0; MemWr = 1'b0; ByteEn = 4'h0; Addr = '0; WrData = '0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", {31'd0, Busy}, 32'd1);
        chk("rst_leds", {24'd0, Leds}, 32'd0);
        chk("rst_digi", {20'd0, RAM_Digi}, 32'd0);
        chk("rst_irq", {31'd0, TimerIrq}, 32'd0);
        do_rd(32'h0, rd);
        chk("rst_rd_blocked", rd, 32'd0);

        // Clear duration, with writes attempted late in the clear
        rst = 1'b0;
        cnt = 0;
        bad = 1'b0;
        while (Busy === 1'b1 && cnt < 2000) begin
            cnt++;
            MemWr  = (cnt == 500) || (cnt == 501);
            Addr   = (cnt == 500) ? 32'h4 : MB + 32'h10;
            WrData = (cnt == 500) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
            ByteEn = 4'hF;
            if (Leds !== 8'd0 || RAM_Digi !== 12'd0 || TimerIrq !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        MemWr = 1'b0;
        chk("clear_cycles", cnt, 512);
        chk("outputs_quiet_during_clear", {31'd0, bad}, 32'd0);
        chk("digi_write_during_busy", {20'd0, RAM_Digi}, 32'd0);
        do_rd(32'h0, rd);   chk("clear_rd_0", rd, 32'd0);
        do_rd(32'h7FC, rd); chk("clear_rd_7fc", rd, 32'd0);
        do_rd(32'h4, rd);   chk("ram_write_during_busy", rd, 32'd0);

        // Table-driven RAM/MMIO accesses
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].op == OP_WR) begin
                do_wr(tbl[i].addr, tbl[i].data, tbl[i].be);
            end else begin
                MemRd = (tbl[i].op == OP_RD); Addr = tbl[i].addr;
                #1;
                chk($sformatf("vec%0d_rd", i), RdData, tbl[i].exp);
                MemRd = 1'b0;
                @(negedge clk);
            end
        end
        chk("leds_out", {24'd0, Leds}, 32'h23);
        chk("digi_out", {20'd0, RAM_Digi}, 32'hBCD);

        // Read and write to the same address in one cycle
        do_wr(32'h10, 32'h1111_1111, 4'hF);
        MemRd = 1'b1; MemWr = 1'b1; Addr = 32'h10; WrData = 32'h2222_2222; ByteEn = 4'hF;
        #1;
        chk("rw_same_old", RdData, 32'h1111_1111);
        @(negedge clk);
        MemWr = 1'b0;
        #1;
        chk("rw_same_new", RdData, 32'h2222_2222);
        MemRd = 1'b0;

        // Timer overflow and interrupt clear
        do_wr(MB + 32'h0, 32'hFFFF_FFF0, 4'hF);
        do_wr(MB + 32'h4, 32'hFFFF_FFFD, 4'hF);
        do_wr(MB + 32'h8, 32'h3, 4'hF);
        do_rd(MB + 32'h4, rd); chk("tl_fd", rd, 32'hFFFF_FFFD);
        step();
        do_rd(MB + 32'h4, rd); chk("tl_fe", rd, 32'hFFFF_FFFE);
        step();
        do_rd(MB + 32'h4, rd); chk("tl_ff", rd, 32'hFFFF_FFFF);
        chk("irq_before_reload", {31'd0, TimerIrq}, 32'd0);
        step();
        do_rd(MB + 32'h4, rd); chk("tl_reload", rd, 32'hFFFF_FFF0);
        chk("irq_on_reload", {31'd0, TimerIrq}, 32'd1);
        do_rd(MB + 32'h8, rd); chk("tcon_status", rd, 32'h7);
        do_wr(MB + 32'h8, 32'h3, 4'hF);
        chk("irq_cleared", {31'd0, TimerIrq}, 32'd0);
        do_rd(MB + 32'h4, rd); chk("tl_after_clear", rd, 32'hFFFF_FFF1);

        // Collision: TL write in the overflow cycle
        do_wr(MB + 32'h4, 32'hFFFF_FFFE, 4'hF);
        step();
        do_rd(MB + 32'h4, rd); chk("coll1_tl_ff", rd, 32'hFFFF_FFFF);
        do_wr(MB + 32'h4, 32'h5, 4'hF);
        do_rd(MB + 32'h4, rd); chk("coll1_tl_wins", rd, 32'h5);
        chk("coll1_irq_set", {31'd0, TimerIrq}, 32'd1);

        // Collision: TCON write in the overflow cycle
        do_wr(MB + 32'h8, 32'h3, 4'hF);
        do_wr(MB + 32'h4, 32'hFFFF_FFFE, 4'hF);
        step();
        do_rd(MB + 32'h4, rd); chk("coll2_tl_ff", rd, 32'hFFFF_FFFF);
        do_wr(MB + 32'h8, 32'h1, 4'hF);
        do_rd(MB + 32'h8, rd); chk("coll2_tcon_wins", rd, 32'h1);
        chk("coll2_irq_low", {31'd0, TimerIrq}, 32'd0);
        do_rd(MB + 32'h4, rd); chk("coll2_tl_reloaded", rd, 32'hFFFF_FFF0);

        // Mid-clear reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_leds", {24'd0, Leds}, 32'd0);
        chk("rst2_busy", {31'd0, Busy}, 32'd1);
        repeat (200) @(negedge clk);
        chk("busy_at_200", {31'd0, Busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(cnt);
        chk("midclear_cycles", cnt, 512);
        do_rd(MB + 32'h4, rd); chk("rst_tl_zero", rd, 32'd0);
        do_rd(MB + 32'h0, rd); chk("rst_th_zero", rd, 32'd0);
        do_rd(MB + 32'h8, rd); chk("rst_tcon_zero", rd, 32'd0);
        do_rd(32'h8, rd);      chk("ram_recleared", rd, 32'd0);
        do_wr(MB + 32'hC, 32'hA5, 4'hF);
        do_rd(MB + 32'hC, rd); chk("leds_rd_a5", rd, 32'h0000_00A5);
        chk("leds_out_a5", {24'd0, Leds}, 32'hA5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
